count_datapath: RTL and testbench
=================================

// Module: count_datapath
// PURPOSE
//  Down-counter datapath driven by the control FSM's reset_out/load/enable strobes.
//  Loads a start value and decrements while enabled, one step per clock.
//  Reports progress back to the controller via busy, tc and a one-cycle done pulse.
//  Sits beside the control FSM as the responder to its three control outputs.
// PARAMETERS
//  WIDTH     8  counter and load_value width in bits
//  PRESCALE  4  enabled cycles per decrement; used only when PRESCALE_EN is defined (>=2)
// PORTS
//  clk         in   1      system clock, all state on rising edge
//  reset       in   1      asynchronous, active-low reset
//  sync_clr    in   1      synchronous clear, from FSM reset_out
//  load        in   1      synchronous load strobe, from FSM load
//  enable      in   1      count enable, from FSM enable
//  load_value  in   WIDTH  value captured on load
//  count       out  WIDTH  current count (register)
//  busy        out  1      high while state==RUN
//  done        out  1      one-cycle pulse, high while state==DONE
//  tc          out  1      terminal count, combinational (count==0)
// BEHAVIOUR
//  States: IDLE, RUN, DONE (2-bit register). busy/done decode state directly.
//  Reset (reset==0, async): count=0, state=IDLE, busy=0, done=0, tc=1, prescaler=0.
//   Applies immediately, including mid-RUN; release is synchronous to clk.
//  Per-edge priority: sync_clr > load > enable.
//  sync_clr: count<=0, state<=IDLE, prescaler<=0; aborts any run, no done.
//  load: count<=load_value, state<=IDLE, prescaler<=0; aborts any run, no done.
//  "step" = enable && count!=0 (&& prescaler terminal when PRESCALE_EN).
//  IDLE: step -> count<=count-1; next state RUN, or DONE if count was 1.
//        enable with count==0 -> no change, stays IDLE, no done.
//  RUN:  step -> count<=count-1; count was 1 -> DONE, else stay RUN.
//        enable low -> hold count, stay RUN (pause), busy stays 1.
//  DONE: lasts exactly one cycle, then IDLE unconditionally; enable ignored.
//        done=1 coincides with count==0, tc=1, busy=0.
//  Decrement never wraps: count==0 is never decremented.
//  Latency: load_value visible on count one edge after load; first decrement on
//   first edge with enable (no extra start cycle).
//  load in DONE cycle: load wins, done still shows 1 that cycle, IDLE next.
// CONFIGURATION
//  PRESCALE_EN defined: WIDTH-independent prescaler counts 0..PRESCALE-1 on
//   cycles with enable && count!=0; a step happens only on the cycle it is at
//   PRESCALE-1 (then wraps to 0). Prescaler holds when enable low; cleared by
//   reset, sync_clr, load. State enters RUN on the first enabled cycle.
//  PRESCALE_EN undefined: no prescaler logic; every enabled cycle is a step.
// TESTING
//  1 load_value=5, load 1 cycle, then enable held -> count 4,3,2,1,0 on 5 edges;
//    busy=1 at 4..1; done=1 exactly one cycle with count=0; IDLE after.
//  2 load 3, enable 1 cycle then low 3 cycles -> count holds 2, busy=1; enable
//    again -> 1,0, done pulse once.
//  3 load=1 and enable=1 same cycle, load_value=9 -> count=9, state IDLE, no step;
//    sync_clr+load+enable same cycle -> count=0, done never asserts.
//  4 count=0, enable held 10 cycles -> count stays 0, tc=1, busy=0, done=0.
//  5 load 200, enable 3 cycles, drop reset mid-cycle -> count=0, busy=0, tc=1
//    before next edge; after release, enable with no load -> nothing happens.
//  6 PRESCALE_EN, PRESCALE=4: load 2, enable held -> count 1 at 4th edge,
//    0 + done at 8th edge; enable low for 2 cycles mid-way delays done by 2.

Source files
------------

// File: rtl/count_datapath.sv
// Down-counter datapath answering the control FSM's clear/load/enable strobes.
// Optional PRESCALE_EN macro enables a prescaler (PRESCALE enabled cycles per step).
module count_datapath #(
  parameter int unsigned WIDTH = 8
`ifdef PRESCALE_EN
  ,
  parameter int unsigned PRESCALE = 4
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sync_clr,
  input  logic             load,
  input  logic             enable,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             tc
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  state_e state;
  logic   active;
  logic   step;

  assign active = enable && (count != '0);

`ifdef PRESCALE_EN
  localparam int unsigned PW = $clog2(PRESCALE);
  localparam logic [PW-1:0] PreLast = PW'(PRESCALE - 1);

  logic [PW-1:0] presc;

  // Only the enabled cycle where the prescaler sits at its last value decrements.
  assign step = active && (presc == PreLast);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc <= '0;
    end else if (sync_clr || load) begin
      presc <= '0;
    end else if (active) begin
      presc <= step ? '0 : presc + PW'(1);
    end
  end
`else
  assign step = active;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
      state <= StIdle;
    end else if (sync_clr) begin
      count <= '0;
      state <= StIdle;
    end else if (load) begin
      count <= load_value;
      state <= StIdle;
    end else begin
      unique case (state)
        StIdle, StRun: begin
          if (step) begin
            count <= count - WIDTH'(1);
            state <= (count == WIDTH'(1)) ? StDone : StRun;
          end else if (active) begin
            state <= StRun;
          end
        end
        StDone:  state <= StIdle;
        default: state <= StIdle;
      endcase
    end
  end

  assign busy = (state == StRun);
  assign done = (state == StDone);
  assign tc   = (count == '0);

endmodule

// File: tb/tb_count_datapath.sv
// Bench for count_datapath: vector table, hand sequences and random stimulus
// checked against a rule-level model.
module tb_count_datapath;

  logic       clk = 1'b0;
  logic       reset;
  logic       sync_clr;
  logic       load;
  logic       enable;
  logic [7:0] load_value;
  logic [7:0] count;
  logic       busy;
  logic       done;
  logic       tc;

  int total = 0;
  int bad = 0;

  count_datapath dut (
    .clk       (clk),
    .reset     (reset),
    .sync_clr  (sync_clr),
    .load      (load),
    .enable    (enable),
    .load_value(load_value),
    .count     (count),
    .busy      (busy),
    .done      (done),
    .tc        (tc)
  );

  always #5 clk = ~clk;

  // Reference model: phase 0=idle, 1=running, 2=done cycle.
  int m_cnt, m_ph, m_pre;
`ifdef PRESCALE_EN
  localparam int P = 4;
`else
  localparam int P = 1;
`endif

  task automatic model_reset();
    m_cnt = 0;
    m_ph  = 0;
    m_pre = 0;
  endtask

  task automatic model_edge(input logic sc, input logic ld, input logic en, input int lv);
    if (sc) begin
      m_cnt = 0; m_ph = 0; m_pre = 0;
    end else if (ld) begin
      m_cnt = lv; m_ph = 0; m_pre = 0;
    end else if (m_ph == 2) begin
      m_ph = 0;
    end else if (en && m_cnt > 0) begin
      m_ph = 1;
      if (m_pre == P - 1) begin
        m_cnt = m_cnt - 1;
        if (m_cnt == 0) m_ph = 2;
      end
      m_pre = (m_pre + 1) % P;
    end
  endtask

  task automatic check(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, ".count"}, int'(count), m_cnt);
    check({tag, ".busy"}, int'(busy), (m_ph == 1) ? 1 : 0);
    check({tag, ".done"}, int'(done), (m_ph == 2) ? 1 : 0);
    check({tag, ".tc"}, int'(tc), (m_cnt == 0) ? 1 : 0);
  endtask

  // Drive at a negedge, let one rising edge pass, compare at the next negedge.
  task automatic cyc(input logic sc, input logic ld, input logic en, input logic [7:0] lv,
                     input string tag);
    sync_clr = sc; load = ld; enable = en; load_value = lv;
    @(posedge clk);
    model_edge(sc, ld, en, int'(lv));
    @(negedge clk);
    check_model(tag);
  endtask

  typedef struct {
    logic       sc, ld, en;
    logic [7:0] lv;
    int         ec;
    logic       eb, ed;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic sc, input logic ld, input logic en, input logic [7:0] lv,
                              input int ec, input logic eb, input logic ed);
    vec_t v;
    v.sc = sc; v.ld = ld; v.en = en; v.lv = lv; v.ec = ec; v.eb = eb; v.ed = ed;
    vecs.push_back(v);
  endfunction

  initial begin
    reset = 1'b0; sync_clr = 1'b0; load = 1'b0; enable = 1'b0; load_value = '0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset.count", int'(count), 0);
    check("reset.busy", int'(busy), 0);
    check("reset.done", int'(done), 0);
    check("reset.tc", int'(tc), 1);
    reset = 1'b1;

`ifndef PRESCALE_EN
    // load 5 then count down with enable held
    add(0, 1, 0, 5, 5, 0, 0);
    add(0, 0, 1, 0, 4, 1, 0);
    add(0, 0, 1, 0, 3, 1, 0);
    add(0, 0, 1, 0, 2, 1, 0);
    add(0, 0, 1, 0, 1, 1, 0);
    add(0, 0, 1, 0, 0, 0, 1);
    add(0, 0, 1, 0, 0, 0, 0);
    add(0, 0, 1, 0, 0, 0, 0);
    // pause mid-run
    add(0, 1, 0, 3, 3, 0, 0);
    add(0, 0, 1, 0, 2, 1, 0);
    add(0, 0, 0, 0, 2, 1, 0);
    add(0, 0, 0, 0, 2, 1, 0);
    add(0, 0, 0, 0, 2, 1, 0);
    add(0, 0, 1, 0, 1, 1, 0);
    add(0, 0, 1, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0);
    // priority: load over enable, clear over everything
    add(0, 1, 1, 9, 9, 0, 0);
    add(1, 1, 1, 7, 0, 0, 0);
    add(0, 0, 1, 0, 0, 0, 0);
    // load during the done cycle wins
    add(0, 1, 0, 1, 1, 0, 0);
    add(0, 0, 1, 0, 0, 0, 1);
    add(0, 1, 1, 4, 4, 0, 0);
    add(0, 0, 1, 0, 3, 1, 0);
    add(1, 0, 1, 0, 0, 0, 0);
    add(0, 0, 1, 0, 0, 0, 0);
    foreach (vecs[i]) begin
      cyc(vecs[i].sc, vecs[i].ld, vecs[i].en, vecs[i].lv, $sformatf("vec%0d", i));
      check($sformatf("tab%0d.count", i), int'(count), vecs[i].ec);
      check($sformatf("tab%0d.busy", i), int'(busy), int'(vecs[i].eb));
      check($sformatf("tab%0d.done", i), int'(done), int'(vecs[i].ed));
      check($sformatf("tab%0d.tc", i), int'(tc), (vecs[i].ec == 0) ? 1 : 0);
    end
`else
    // prescaler: load 2, count reaches 1 on 4th enabled edge, 0 on 8th
    cyc(0, 1, 0, 2, "pre.load");
    for (int i = 1; i <= 8; i++) begin
      cyc(0, 0, 1, 0, "pre.run");
      if (i == 4) check("pre.edge4", int'(count), 1);
      if (i == 8) check("pre.edge8.done", int'(done), 1);
    end
    cyc(0, 1, 0, 2, "pre.load2");
    for (int i = 1; i <= 10; i++) begin
      cyc(0, 0, (i == 3 || i == 4) ? 1'b0 : 1'b1, 0, "pre.pause");
      if (i == 9) check("pre.pause.notyet", int'(done), 0);
      if (i == 10) check("pre.pause.done", int'(done), 1);
    end
`endif

    // enable on an empty counter does nothing
    for (int i = 0; i < 10; i++) cyc(0, 0, 1, 0, "zero");
    check("zero.count", int'(count), 0);

    // async reset mid-run, effective before the next edge
    cyc(0, 1, 0, 200, "ar.load");
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0, "ar.run");
    #2 reset = 1'b0;
    #1;
    model_reset();
    check("ar.count", int'(count), 0);
    check("ar.busy", int'(busy), 0);
    check("ar.tc", int'(tc), 1);
    @(negedge clk);
    check_model("ar.hold");
    reset = 1'b1;
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0, "ar.after");

    // random stimulus
    for (int i = 0; i < 3000; i++) begin
      logic sc, ld, en;
      logic [7:0] lv;
      sc = ($urandom_range(0, 39) == 0);
      ld = ($urandom_range(0, 9) == 0);
      en = ($urandom_range(0, 3) != 0);
      lv = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 6));
      cyc(sc, ld, en, lv, "rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
